// File: rtl/pcm_delay_array.sv
// Per-channel integer-sample delay line with shadow/active delay registers and atomic commit.
// Optional `DELAY_RAMP_EN: committed delays are approached one sample step per pcm_valid.
module pcm_delay_array #(
  parameter int NUM_CH  = 16,
  parameter int DATA_W  = 19,
  parameter int DEPTH   = 32,
  parameter int DELAY_W = $clog2(DEPTH),
  parameter int CH_W    = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pcm_valid,
  input  logic [NUM_CH*DATA_W-1:0] pcm_data,
  input  logic                     cfg_we,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [DELAY_W-1:0]       cfg_delay,
  input  logic                     cfg_commit,
  output logic                     commit_pending,
  output logic                     delayed_valid,
  output logic [NUM_CH*DATA_W-1:0] delayed_pcm_data
);

  logic [DATA_W-1:0]  mem [NUM_CH][DEPTH];
  logic [DELAY_W-1:0] wr_ptr;
  logic [DELAY_W:0]   fill;
  logic [DELAY_W-1:0] shadow     [NUM_CH];
  logic [DELAY_W-1:0] active     [NUM_CH];
  logic [DELAY_W-1:0] shadow_fwd [NUM_CH];
  logic [DELAY_W-1:0] eff        [NUM_CH];
  logic [DATA_W-1:0]  rd_data    [NUM_CH];

  // A cfg_we in the same cycle as a commit must be seen by that commit.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      shadow_fwd[c] = shadow[c];
      if (cfg_we && cfg_ch == CH_W'(c)) shadow_fwd[c] = cfg_delay;
    end
  end

`ifdef DELAY_RAMP_EN
  logic [DELAY_W-1:0] target [NUM_CH];
  logic               all_done;

  // Delay used by this sample: one step from active toward target.
  always_comb begin
    all_done = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      eff[c] = active[c];
      if (active[c] < target[c])      eff[c] = active[c] + 1'b1;
      else if (active[c] > target[c]) eff[c] = active[c] - 1'b1;
      if (eff[c] != target[c]) all_done = 1'b0;
    end
  end
`else
  logic commit_now;

  assign commit_now = pcm_valid & (commit_pending | cfg_commit);

  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      eff[c] = commit_now ? shadow_fwd[c] : active[c];
  end
`endif

  // Delay 0 bypasses the RAM; delays reaching past captured history read as 0.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      rd_data[c] = '0;
      if (eff[c] == '0)
        rd_data[c] = pcm_data[c*DATA_W +: DATA_W];
      else if ({1'b0, eff[c]} <= fill)
        rd_data[c] = mem[c][wr_ptr - eff[c]];
    end
  end

  // NOTE: the sample RAM has no reset; stale contents are hidden by the fill mask.
  always_ff @(posedge clk) begin
    if (pcm_valid) begin
      for (int c = 0; c < NUM_CH; c++)
        mem[c][wr_ptr] <= pcm_data[c*DATA_W +: DATA_W];
    end
  end

  // NOTE: registered state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr           <= '0;
      fill             <= '0;
      delayed_valid    <= 1'b0;
      delayed_pcm_data <= '0;
      commit_pending   <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        shadow[c] <= '0;
        active[c] <= '0;
`ifdef DELAY_RAMP_EN
        target[c] <= '0;
`endif
      end
    end else begin
      delayed_valid <= pcm_valid;
      for (int c = 0; c < NUM_CH; c++)
        shadow[c] <= shadow_fwd[c];

      if (pcm_valid) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (fill != (DELAY_W+1)'(DEPTH)) fill <= fill + 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
          delayed_pcm_data[c*DATA_W +: DATA_W] <= rd_data[c];
          active[c]                            <= eff[c];
        end
      end

`ifdef DELAY_RAMP_EN
      if (cfg_commit) begin
        commit_pending <= 1'b1;
        for (int c = 0; c < NUM_CH; c++)
          target[c] <= shadow_fwd[c];
      end else if (pcm_valid && all_done) begin
        commit_pending <= 1'b0;
      end
`else
      commit_pending <= commit_now ? 1'b0 : (commit_pending | cfg_commit);
`endif
    end
  end

endmodule

// File: tb/tb_pcm_delay_array.sv
// Directed bench for pcm_delay_array; expected outputs come from a small behavioural model.
// Also exercises the ramp behaviour when built with DELAY_RAMP_EN defined.
module tb_pcm_delay_array;
  localparam int NUM_CH  = 16;
  localparam int DATA_W  = 19;
  localparam int DEPTH   = 32;
  localparam int DELAY_W = 5;
  localparam int CH_W    = 4;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     pcm_valid = 1'b0;
  logic [NUM_CH*DATA_W-1:0] pcm_data = '0;
  logic                     cfg_we = 1'b0;
  logic [CH_W-1:0]          cfg_ch = '0;
  logic [DELAY_W-1:0]       cfg_delay = '0;
  logic                     cfg_commit = 1'b0;
  logic                     commit_pending;
  logic                     delayed_valid;
  logic [NUM_CH*DATA_W-1:0] delayed_pcm_data;

  pcm_delay_array #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .pcm_valid(pcm_valid), .pcm_data(pcm_data),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay), .cfg_commit(cfg_commit),
    .commit_pending(commit_pending), .delayed_valid(delayed_valid),
    .delayed_pcm_data(delayed_pcm_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: strobe indices seen since reset and per-channel delays.
  int hist_n[$];
  int mdelay  [NUM_CH];
  int mshadow [NUM_CH];
  int mtarget [NUM_CH];
  bit mpend;
  int last_exp[NUM_CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    hist_n.delete();
    mpend = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      mdelay[c] = 0; mshadow[c] = 0; mtarget[c] = 0; last_exp[c] = 0;
    end
  endtask

  function automatic logic [31:0] out_ch(input int c);
    return 32'(delayed_pcm_data[c*DATA_W +: DATA_W]);
  endfunction

  // Called at a negedge with rst high; checks the async clear before any clock edge.
  task automatic check_cleared(input string tag);
    #1;
    check({tag, " valid"}, 32'(delayed_valid), 0);
    check({tag, " pending"}, 32'(commit_pending), 0);
    for (int c = 0; c < NUM_CH; c++)
      check($sformatf("%s ch%0d", tag, c), out_ch(c), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    check_cleared("reset");
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // Config-only cycle (no pcm_valid). Starts and ends at a negedge.
  task automatic cfg(input bit we, input int ch, input int dly, input bit commit);
    cfg_we = we; cfg_ch = CH_W'(ch); cfg_delay = DELAY_W'(dly); cfg_commit = commit;
    if (we) mshadow[ch] = dly;
    if (commit) begin
      mpend = 1'b1;
`ifdef DELAY_RAMP_EN
      for (int c = 0; c < NUM_CH; c++) mtarget[c] = mshadow[c];
`endif
    end
    @(negedge clk);
    cfg_we = 1'b0; cfg_commit = 1'b0;
    check("cfg pending", 32'(commit_pending), 32'(mpend));
  endtask

  // One strobe with optional config in the same cycle. Starts and ends at a negedge,
  // so consecutive calls give back-to-back pcm_valid.
  task automatic strobe(input int n, input bit we = 1'b0, input int ch = 0,
                        input int dly = 0, input bit commit = 1'b0);
    int cnt;
    bit done;
    pcm_valid = 1'b1;
    for (int c = 0; c < NUM_CH; c++)
      pcm_data[c*DATA_W +: DATA_W] = DATA_W'(100*c + n);
    cfg_we = we; cfg_ch = CH_W'(ch); cfg_delay = DELAY_W'(dly); cfg_commit = commit;
    if (we) mshadow[ch] = dly;
`ifdef DELAY_RAMP_EN
    done = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (mdelay[c] < mtarget[c]) mdelay[c]++;
      else if (mdelay[c] > mtarget[c]) mdelay[c]--;
      if (mdelay[c] != mtarget[c]) done = 1'b0;
    end
    if (commit) begin
      mpend = 1'b1;
      for (int c = 0; c < NUM_CH; c++) mtarget[c] = mshadow[c];
    end else if (done) begin
      mpend = 1'b0;
    end
`else
    done = mpend | commit;
    if (done) begin
      for (int c = 0; c < NUM_CH; c++) mdelay[c] = mshadow[c];
      mpend = 1'b0;
    end
`endif
    cnt = hist_n.size();
    for (int c = 0; c < NUM_CH; c++) begin
      if (mdelay[c] == 0)        last_exp[c] = 100*c + n;
      else if (mdelay[c] > cnt)  last_exp[c] = 0;
      else                       last_exp[c] = 100*c + hist_n[cnt - mdelay[c]];
    end
    hist_n.push_back(n);
    @(negedge clk);
    pcm_valid = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0;
    check($sformatf("n%0d valid", n), 32'(delayed_valid), 1);
    check($sformatf("n%0d pending", n), 32'(commit_pending), 32'(mpend));
    for (int c = 0; c < NUM_CH; c++)
      check($sformatf("n%0d ch%0d", n, c), out_ch(c), 32'(last_exp[c]));
  endtask

  // Idle cycle: valid must drop and the outputs must hold.
  task automatic gap();
    @(negedge clk);
    check("gap valid", 32'(delayed_valid), 0);
    check("gap hold ch0", out_ch(0), 32'(last_exp[0]));
    check("gap hold ch15", out_ch(15), 32'(last_exp[15]));
  endtask

  initial begin
    model_clear();

    // 1: all delays 0, output equals input one clock later
    do_reset();
    for (int n = 1; n <= 40; n++) begin
      strobe(n);
      if (n % 4 == 0) gap();
    end

    // 2: ch3 delay 5, first 5 strobes masked
    do_reset();
    cfg(1'b1, 3, 5, 1'b1);
    for (int n = 1; n <= 40; n++) begin
      strobe(n);
      if (n % 7 == 0) gap();
    end

    // 3: ch15 delay 31 across two pointer wraps
    do_reset();
    for (int n = 1; n <= 35; n++) strobe(n);
    cfg(1'b1, 15, 31, 1'b1);
    for (int n = 36; n <= 70; n++) strobe(n);

    // 4: shadow write without commit is inert; commit with strobe applies at once,
    //    including a cfg_we forwarded in the commit cycle
    do_reset();
    for (int n = 1; n <= 10; n++) strobe(n);
    cfg(1'b1, 2, 7, 1'b0);
    strobe(11);
    strobe(12);
    strobe(13, 1'b1, 5, 3, 1'b1);
    for (int n = 14; n <= 20; n++) strobe(n);

    // 5: asynchronous reset mid-stream, then stale RAM must stay masked
    do_reset();
    cfg(1'b1, 3, 5, 1'b1);
    for (int n = 1; n <= 8; n++) strobe(n);
    cfg(1'b0, 0, 0, 1'b1);
    #2 rst = 1'b1;
    check_cleared("midrst");
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    cfg(1'b1, 3, 5, 1'b1);
    for (int n = 1; n <= 8; n++) strobe(n);

`ifdef DELAY_RAMP_EN
    // 6: ramp 0 -> 4 one step per strobe
    do_reset();
    cfg(1'b1, 0, 4, 1'b1);
    for (int n = 1; n <= 6; n++) strobe(n);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
